// File: rtl/game_timer.sv
// Countdown game timer: prescaled tick, penalty on miss, BCD display scan.
// Optional pause support is compiled in with `define PAUSE_EN.
module game_timer #(
  parameter int DIGITS     = 8,
  parameter int TICK_DIV   = 5000,
  parameter int INIT_TICKS = 1800000,
  parameter int PENALTY    = 10,
  parameter int SCAN_DIV   = 3,
  parameter int DP_POS     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              miss,
`ifdef PAUSE_EN
  input  logic              pause,
`endif
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              running,
  output logic              game_over
);

  localparam int W  = $clog2(INIT_TICKS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(W + 1);
  localparam int SW = (SCAN_DIV > 0) ? SCAN_DIV : 1;
  localparam int BW = 4 * DIGITS;

`ifdef PAUSE_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
`endif

  state_t state, state_nxt;

  logic [PW-1:0] presc;
  logic          tick;
  logic [W-1:0]  count, count_nxt;
  logic [31:0]   dec;

  logic          boot, busy, pending, req, load;
  logic [CW-1:0] nbit;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bcd, adj, bcd_nxt, digits;

  logic [SW-1:0] scnt;
  logic          slot_end;
  logic [IW-1:0] idx;
  logic [3:0]    cur;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Free-running prescaler producing the countdown tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // State and count registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= W'(INIT_TICKS);
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next state and saturating count update; OVER entered on the zeroing edge
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dec       = 32'd0;
    if (tick) dec = dec + 32'd1;
    if (miss) dec = dec + 32'(PENALTY);
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
`ifdef PAUSE_EN
        if (pause) state_nxt = PAUSED;
        else
`endif
        if (dec != 32'd0) begin
          if (32'(count) > dec) begin
            count_nxt = W'(32'(count) - dec);
          end else begin
            count_nxt = '0;
            state_nxt = OVER;
          end
        end
      end
`ifdef PAUSE_EN
      PAUSED: if (pause) state_nxt = RUN;
`endif
      OVER: state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    running   = (state == RUN);
    game_over = (state == OVER);
  end

  assign req  = boot | (count_nxt != count);
  assign load = ~busy & (req | pending);

  // Double-dabble step: add 3 to digits >= 5, then shift in next bit
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_nxt = {adj[BW-2:0], shreg[W-1]};
  end

  // Converter: snapshot, W shifts, then atomic commit to digits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      boot    <= 1'b1;
      busy    <= 1'b0;
      pending <= 1'b0;
      nbit    <= '0;
      shreg   <= '0;
      bcd     <= '0;
      digits  <= '0;
    end else begin
      boot <= 1'b0;
      if (load) begin
        busy    <= 1'b1;
        pending <= 1'b0;
        nbit    <= '0;
        shreg   <= count_nxt;
        bcd     <= '0;
      end else begin
        if (req) pending <= 1'b1;
        if (busy) begin
          if (nbit == CW'(W)) begin
            digits <= bcd;
            busy   <= 1'b0;
          end else begin
            bcd   <= bcd_nxt;
            shreg <= shreg << 1;
            nbit  <= nbit + 1'b1;
          end
        end
      end
    end
  end

  assign slot_end = (SCAN_DIV == 0) ? 1'b1 :
                    (scnt == SW'((1 << SCAN_DIV) - 1));

  // Digit scan: advance index once per slot, wrap at the last digit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scnt <= '0;
      idx  <= '0;
    end else begin
      scnt <= scnt + 1'b1;
      if (slot_end) begin
        if (idx == IW'(DIGITS - 1)) idx <= '0;
        else                        idx <= idx + 1'b1;
      end
    end
  end

  // Display drive: anode select, segment decode, decimal point
  always_comb begin
    an  = ~(DIGITS'(1) << idx);
    cur = digits[4*idx +: 4];
    dp  = (32'(idx) == DP_POS);
    unique case (cur)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b1000000;
    endcase
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter DIGITS, default 8, number of display digits (2..8).
REQ-002 Parameter TICK_DIV, default 5000, clock cycles per countdown tick.
REQ-003 Parameter INIT_TICKS, default 1800000, countdown start value in ticks (< 10^DIGITS).
REQ-004 Parameter PENALTY, default 10, ticks removed per miss.
REQ-005 Parameter SCAN_DIV, default 3, log2 of clock cycles per digit scan slot.
REQ-006 Parameter DP_POS, default 2, digit index driving the decimal point.
REQ-007 clock  input  1  system clock, rising edge.
REQ-008 reset  input  1  reset, asynchronous, active-high.
REQ-009 start  input  1  level/pulse; begins countdown from IDLE.
REQ-010 miss  input  1  one-cycle pulse; applies penalty.
REQ-011 pause  input  1  one-cycle pulse; toggles RUN/PAUSED (present only with PAUSE_EN).
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-013 dp  output  1  decimal point, active-high.
REQ-014 an  output  DIGITS  digit enables, active-low one-hot.
REQ-015 running  output  1  high in RUN.
REQ-016 game_over  output  1  high in OVER, sticky until reset.

Function
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 freely from reset and SHALL pulse tick for one cycle at TICK_DIV-1.
REQ-018 FSM states SHALL be IDLE, RUN, PAUSED and OVER: IDLE->RUN on start; RUN->OVER when the count reaches 0; start in RUN/PAUSED/OVER is ignored.
REQ-019 The count SHALL be a binary register of width clog2(INIT_TICKS+1) and SHALL load INIT_TICKS at reset.
REQ-020 In RUN, tick SHALL decrement the count by 1; miss SHALL subtract PENALTY; both in the same cycle SHALL subtract PENALTY+1.
REQ-021 Subtraction SHALL saturate at 0; the cycle the count becomes 0, the state SHALL move to OVER (game_over visible the following cycle).
REQ-022 miss and tick SHALL have no effect in IDLE, PAUSED or OVER.
REQ-023 A sequential double-dabble converter SHALL snapshot the count on a request and SHALL update all digit registers atomically after exactly W+1 cycles (W = count width).
REQ-024 Requests SHALL be raised one cycle after reset release, on every count change; a request while busy SHALL set a single pending flag serviced immediately after completion.
REQ-025 The scan counter SHALL advance the digit index every 2^SCAN_DIV cycles, wrapping DIGITS-1 -> 0, with an[index] low and all other an bits high.
REQ-026 seg SHALL decode digit values 0-9 to standard patterns and any other value to a dash (7'b1000000); dp SHALL be high only when index == DP_POS.

Reset
REQ-027 Reset SHALL force: IDLE, count = INIT_TICKS, prescaler 0, scan index 0, digits 0, converter idle, pending 0, running 0, game_over 0, an = ~1, seg = 0-pattern.
REQ-028 Reset mid-conversion or mid-countdown SHALL abort all activity with no residual pending request.

Configuration
REQ-029 With PAUSE_EN defined, the pause port SHALL exist, pause SHALL toggle RUN<->PAUSED, be ignored in IDLE/OVER, and take priority over a same-cycle miss; the prescaler keeps running.
REQ-030 Without PAUSE_EN, the pause port and PAUSED state SHALL be absent and RUN SHALL never suspend.

Verification (DIGITS=4, TICK_DIV=4, INIT_TICKS=20, PENALTY=5, SCAN_DIV=1)
REQ-031 Reset, wait 12 cycles, no start -> digits read 0020, running 0, count constant.
REQ-032 start pulse -> running 1 next cycle; after 8 ticks (32 cycles) -> count 12, digits 0012 within W+1 cycles.
REQ-033 miss coincident with tick at count 7 -> count 1; next tick -> count 0, game_over 1, running 0.
REQ-034 miss at count 3 -> count 0 (saturated), OVER; further start/miss -> no change.
REQ-035 PAUSE_EN: pause at count 15, wait 40 cycles, miss -> count stays 15; pause again -> decrements resume.
REQ-036 Scan check: an cycles 1110,1101,1011,0111 every 2 cycles; dp high only while an=1011; reset mid-run -> count 20, IDLE.
